// File: rtl/multi_timer.sv
// multi_timer: independent one-shot/periodic timer channels with single-cycle terminal-count pulses.
// Defining MULTI_TIMER_PRESCALER_EN adds a shared free-running prescaler that gates all channels.
module multi_timer #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 30,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [PRESC_WIDTH-1:0]    prescale,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] count
);
    logic tick;
`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PRESC_WIDTH-1:0] presc;
    assign tick = presc == prescale;
    // >= lets a shrinking prescale value wrap the counter instead of running to overflow
    always_ff @(posedge clk or posedge reset)
        if (reset) presc <= '0;
        else presc <= (presc >= prescale) ? '0 : presc + 1'b1;
`else
    logic unused_prescale;
    assign tick = 1'b1;
    assign unused_prescale = ^prescale;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t             state;
        logic [WIDTH-1:0]   cnt;
        logic [WIDTH-1:0]   lim;
        logic               per;
        logic               pls;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                lim   <= '0;
                per   <= 1'b0;
                pls   <= 1'b0;
            end else begin
                pls <= 1'b0;
                if (start[g]) begin
                    state <= RUN;
                    cnt   <= '0;
                    lim   <= limit[g*WIDTH +: WIDTH];
                    per   <= periodic[g];
                end else if (state == RUN) begin
                    if (stop[g]) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt == lim) begin
                            pls   <= 1'b1;
                            cnt   <= '0;
                            state <= per ? RUN : IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            end
        end
        assign pulse[g] = pls;
        assign busy[g]  = state == RUN;
        assign count[g*WIDTH +: WIDTH] = cnt;
    end
endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed test-plan steps plus random traffic checked against an elapsed-tick model.
module tb_multi_timer;
    localparam int N  = 4;
    localparam int W  = 30;
    localparam int PW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   start, stop, periodic;
    logic [N*W-1:0] limit;
    logic [PW-1:0]  prescale;
    logic [N-1:0]   pulse, busy;
    logic [N*W-1:0] count;

    multi_timer #(.CHANNELS(N), .WIDTH(W), .PRESC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .periodic(periodic),
        .limit(limit), .prescale(prescale), .pulse(pulse), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a running channel tracks ticks elapsed since its last start.
    bit          m_run [N];
    bit          m_per [N];
    longint      m_lim [N];
    longint      m_e   [N];
    logic [N-1:0] m_pulse;
    longint      pc;
    longint      p;

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_run[i];
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_count();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++)
            r[i*W +: W] = m_run[i] ? W'(m_e[i] % (m_lim[i] + 1)) : '0;
        return r;
    endfunction

    task automatic check(input string tag);
        logic [N-1:0]   eb;
        logic [N*W-1:0] ec;
        eb = exp_busy();
        ec = exp_count();
        checks += 3;
        assert (pulse === m_pulse) else begin
            errors++;
            $error("FAIL %s pulse: observed %b expected %b", tag, pulse, m_pulse);
        end
        assert (busy === eb) else begin
            errors++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
        end
        assert (count === ec) else begin
            errors++;
            $error("FAIL %s count: observed %h expected %h", tag, count, ec);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_per[i] = 0; m_lim[i] = 0; m_e[i] = 0;
        end
        m_pulse = '0;
        pc = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] st, sp, pe, input logic [N*W-1:0] lv);
        bit tk;
`ifdef MULTI_TIMER_PRESCALER_EN
        tk = (pc == p);
        pc = (pc >= p) ? 0 : pc + 1;
`else
        tk = 1;
`endif
        for (int i = 0; i < N; i++) begin
            m_pulse[i] = 1'b0;
            if (st[i]) begin
                m_run[i] = 1; m_per[i] = pe[i]; m_lim[i] = longint'(lv[i*W +: W]); m_e[i] = 0;
            end else if (m_run[i] && sp[i]) begin
                m_run[i] = 0; m_e[i] = 0;
            end else if (m_run[i] && tk) begin
                m_e[i]++;
                if (m_e[i] % (m_lim[i] + 1) == 0) begin
                    m_pulse[i] = 1'b1;
                    if (!m_per[i]) begin
                        m_run[i] = 0; m_e[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] st, sp, pe, input string tag);
        @(negedge clk);
        start = st; stop = sp; periodic = pe;
`ifndef MULTI_TIMER_PRESCALER_EN
        prescale = PW'($urandom);
`endif
        @(posedge clk);
        model_edge(st, sp, pe, limit);
        #1 check(tag);
    endtask

    task automatic set_lim(input int ch, input logic [W-1:0] v);
        limit[ch*W +: W] = v;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        #1 check("in_reset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = N'($urandom); stop = N'($urandom); periodic = N'($urandom);
            limit = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1 check("in_reset");
        end
        @(negedge clk);
        start = '0; stop = '0; periodic = '0; limit = '0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = '0; stop = '0; periodic = '0; limit = '0;
`ifdef MULTI_TIMER_PRESCALER_EN
        p = 4;
`else
        p = 0;
`endif
        prescale = PW'(p);
        model_clear();
        reset_dut();
        repeat (20) step('0, '0, '0, "idle");
        set_lim(0, 3);
        step(4'b0001, '0, 4'b0001, "ch0_start");
        repeat (12) step('0, '0, '0, "ch0_periodic");
        set_lim(1, 5);
        step(4'b0010, '0, '0, "ch1_start");
        repeat (50) step('0, '0, '0, "ch1_oneshot");
        set_lim(2, 9);
        step(4'b0100, '0, 4'b0100, "ch2_start");
        repeat (6) step('0, '0, '0, "ch2_run");
        set_lim(2, 2);
        step(4'b0100, '0, 4'b0100, "ch2_restart");
        repeat (5) step('0, '0, '0, "ch2_after");
        step(4'b0100, 4'b0100, 4'b0100, "ch2_start_stop");
        repeat (4) step('0, '0, '0, "ch2_after2");
        set_lim(3, 0);
        step(4'b1000, '0, 4'b1000, "ch3_start");
        repeat (2) step('0, '0, '0, "ch3_lim0");
        step('0, 4'b1000, '0, "ch3_stop");
        repeat (3) step('0, '0, '0, "ch3_idle");
        step('0, 4'b0101, '0, "stop_all");
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] st, sp;
            for (int i = 0; i < N; i++) begin
                st[i] = ($urandom_range(0, 15) == 0);
                sp[i] = ($urandom_range(0, 31) == 0);
                set_lim(i, ($urandom_range(0, 30) == 0) ? W'($urandom) : W'($urandom_range(0, 12)));
            end
            if (k == 1500) begin
                reset_dut();
                repeat (2) step('0, '0, '0, "post_reset");
            end
            step(st, sp, N'($urandom), "random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
# multi_timer

Multi-channel programmable timer that generates single-cycle timing pulses for game logic: fall-speed ticks, debounce windows and display refresh strobes. Each channel is independently started, stopped, loaded with its own terminal count and run in one-shot or periodic mode. All channels share one clock and an optional common prescaler. This block replaces the fixed single-channel timer instances.

## Interface
- CHANNELS, 4, number of independent timer channels (1..16)
- WIDTH, 30, bits per channel counter and limit
- PRESC_WIDTH, 16, bits of shared prescaler reload value
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  CHANNELS  per-channel load/restart strobe, sampled at clk edge
- stop  input  CHANNELS  per-channel abort strobe
- periodic  input  CHANNELS  mode per channel, sampled with start: 1 = periodic, 0 = one-shot
- limit  input  CHANNELS*WIDTH  terminal count per channel, channel i at [i*WIDTH +: WIDTH], sampled with start
- prescale  input  PRESC_WIDTH  shared prescaler reload; tick every prescale+1 clocks (used only with MULTI_TIMER_PRESCALER_EN)
- pulse  output  CHANNELS  one-clock pulse per channel at terminal count, registered
- busy  output  CHANNELS  channel is in RUN
- count  output  CHANNELS*WIDTH  current counter value per channel

## Operation
- Per-channel FSM states: IDLE and RUN.
- On reset: all channels IDLE; count, latched limit, latched mode, pulse, busy and the prescaler are 0.
- IDLE: start[i] latches limit_i and periodic[i], clears count to 0 and enters RUN. stop has no effect in IDLE.
- RUN, on a tick with count != latched limit: count increments by 1.
- RUN, on a tick with count == latched limit: pulse[i]=1 for the next cycle and count returns to 0. Periodic mode stays in RUN. One-shot mode goes to IDLE.
- RUN without a tick: count holds.
- start[i] in RUN restarts the channel: new limit and mode are latched, count=0, and no pulse is generated for the aborted period.
- stop[i] in RUN: go to IDLE, count=0, no pulse.
- start and stop asserted together: start wins.
- A terminal-count event in the same cycle as start: start wins and no pulse is generated.
- limit=0: a pulse on every tick while in RUN; a one-shot channel pulses once.
- The counter never wraps past the limit. All compares are unsigned, WIDTH bits. Channels are fully independent.
- Changes to the limit input while in RUN have no effect until the next start.

## Timing
- Tick = 1 on every clock when the prescaler is compiled out.
- Start sampled at edge E0: busy=1 and count=0 after E0.
- With the tick always high: pulse is high in the cycle after edge E0+L+1. The periodic period is L+1 clocks.
- One-shot: busy falls at the same edge at which pulse rises.
- pulse is always exactly one clock wide.
- Reset deassertion mid-operation: every channel restarts from IDLE. No pulse is emitted during reset or in the first cycle after reset.

## Configuration
- MULTI_TIMER_PRESCALER_EN defined:
  - A free-running shared counter counts 0..prescale, and tick=1 for one clock when it equals prescale. All channels advance only on tick, so the period is (L+1)*(prescale+1) clocks.
  - The prescaler is not reset by start. Phase is relative to the free-running counter, so the first period may be shortened by up to prescale clocks.
  - prescale is sampled continuously. prescale=0 gives a tick every clock.
  - Changing prescale to a value below the current prescaler count wraps the prescaler to 0 on the next clock.
- Not defined: no prescaler logic. Tick is constant 1 and the prescale port is ignored.

## Test plan
- Reset with all inputs toggling, then release -> pulse=0, busy=0 and all count=0 for 20 cycles with no start.
- Ch0 periodic, limit=3, no prescaler -> pulse[0] high every 4 clocks (first in the cycle after E0+4). busy[0] stays 1; count cycles 0,1,2,3.
- Ch1 one-shot, limit=5 -> exactly one pulse in the cycle after E0+6; busy[1] falls at the same edge; no further pulses over 50 cycles.
- Ch2 periodic, limit=9; restart at count=6 with limit=2 -> no pulse for the old period; next pulse 3 clocks after the restart edge. Start+stop together in a later cycle -> channel restarted, not stopped.
- Ch3 periodic, limit=0, with stop in the cycle after the second pulse -> pulses on consecutive clocks, then pulse=0, busy=0, count=0.
- MULTI_TIMER_PRESCALER_EN with prescale=4, ch0 periodic limit=1 -> pulse period exactly 10 clocks after the first pulse. Other channels are unaffected.
